fetch_pcgen: RTL and testbench

//  Fetch-stage PC generator and instruction-bus sequencer.

---
 rtl/fetch_pcgen_pkg.sv | 22 ++
 rtl/fetch_pcgen_if.sv | 31 +++
 rtl/fetch_perf_counter.sv | 15 +
 rtl/fetch_pcgen.sv | 111 +++++++++++
 tb/tb_fetch_pcgen.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pcgen_pkg.sv
// Shared types for the fetch-stage PC generator.
package fetch_pcgen_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
    typedef logic        u1;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        u64 pc;
        u32 instr;
    } fetch_data_t;

    localparam u64 PC_STEP = 64'd4;

endpackage

// File: rtl/fetch_pcgen_if.sv
// Instruction-bus request/response and decode-side valid/ready bundle.
interface fetch_pcgen_if;
    import fetch_pcgen_pkg::*;

    u1  ireq_valid;
    u64 ireq_addr;
    u1  iresp_addr_ok;
    u1  iresp_data_ok;
    u32 iresp_data;
    u1  out_valid;
    u1  out_ready;
    u64 out_pc;
    u32 out_instr;

    // Fetch unit side
    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_addr_ok, iresp_data_ok, iresp_data,
        output out_valid, out_pc, out_instr,
        input  out_ready
    );

    // Bus and decode side
    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_addr_ok, iresp_data_ok, iresp_data,
        input  out_valid, out_pc, out_instr,
        output out_ready
    );

endinterface

// File: rtl/fetch_perf_counter.sv
// 64-bit wrapping event counter with enable.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [63:0] count
);

    // Count one per enabled cycle; wraps naturally at 2^64.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   count <= 64'd0;
        else if (en) count <= count + 64'd1;
    end

endmodule

// File: rtl/fetch_pcgen.sv
// Fetch-stage PC generator and instruction-bus sequencer.
// Optional FETCH_PERF_EN adds fetched-instruction and redirect counters.
//
// state | meaning
// REQ   | request at pc outstanding, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// HOLD  | instruction captured, presented to decode
// DROP  | squashed request in flight, discard its data_ok
module fetch_pcgen
    import fetch_pcgen_pkg::*;
#(
    parameter u64 PCINIT = 64'h0000_0000_8000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSel,
    input  u64            pc_target,
    fetch_pcgen_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output u64            perf_fetched,
    output u64            perf_redirects
`endif
);

    fetch_state_t state_q, state_d;
    u64           pc_q, pc_d;
    fetch_data_t  held_q, held_d;
    logic         capture;

    // State, pc and held instruction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= PCINIT;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            held_q  <= held_d;
        end
    end

    // Next-state, pc update and capture; a redirect overrides every transition.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        held_d  = held_q;
        capture = 1'b0;
        case (state_q)
            REQ: begin
                if (PCSel)
                    state_d = (bus.iresp_addr_ok && !bus.iresp_data_ok) ? DROP : REQ;
                else if (bus.iresp_addr_ok && bus.iresp_data_ok) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end else if (bus.iresp_addr_ok)
                    state_d = WAIT;
            end
            WAIT: begin
                if (PCSel)
                    state_d = bus.iresp_data_ok ? REQ : DROP;
                else if (bus.iresp_data_ok) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                if (PCSel)
                    state_d = REQ;
                else if (bus.out_ready) begin
                    state_d = REQ;
                    pc_d    = pc_q + PC_STEP;
                end
            end
            DROP: begin
                if (!PCSel && bus.iresp_data_ok)
                    state_d = REQ;
            end
            default: state_d = REQ;
        endcase
        if (capture)
            held_d = '{pc: pc_q, instr: bus.iresp_data};
        if (PCSel)
            pc_d = pc_target;
    end

    // Bus request is held off while reset is asserted; HOLD's valid is killed by a redirect.
    assign bus.ireq_valid = !reset && (state_q != HOLD);
    assign bus.ireq_addr  = pc_q;
    assign bus.out_valid  = (state_q == HOLD) && !PCSel;
    assign bus.out_pc     = held_q.pc;
    assign bus.out_instr  = held_q.instr;

`ifdef FETCH_PERF_EN
    fetch_perf_counter u_cnt_fetched (
        .clk   (clk),
        .reset (reset),
        .en    (bus.out_valid && bus.out_ready),
        .count (perf_fetched)
    );

    fetch_perf_counter u_cnt_redirects (
        .clk   (clk),
        .reset (reset),
        .en    (PCSel),
        .count (perf_redirects)
    );
`endif

endmodule

// File: tb/tb_fetch_pcgen.sv
// Directed bench for fetch_pcgen.
module tb_fetch_pcgen;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSel;
    logic [63:0] pc_target;
`ifdef FETCH_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_redirects;
`endif

    int total = 0;
    int bad   = 0;

    fetch_pcgen_if bus ();

    fetch_pcgen #(.PCINIT(64'h0000_0000_8000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .PCSel     (PCSel),
        .pc_target (pc_target),
        .bus       (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        PCSel = 1'b0;
        pc_target = '0;
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("t1_ireq_valid", 64'(bus.ireq_valid), 64'd1);
        chk("t1_addr", bus.ireq_addr, 64'h8000_0000);
`ifdef FETCH_PERF_EN
        chk("perf_f_rst", perf_fetched, 64'd0);
        chk("perf_r_rst", perf_redirects, 64'd0);
`endif

        // 1: same-cycle addr_ok/data_ok, immediate accept
        bus.iresp_addr_ok = 1'b1;
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data = 32'h0000_0013;
        bus.out_ready = 1'b1;
        step();
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_out_pc", bus.out_pc, 64'h8000_0000);
        chk("t1_out_instr", 64'(bus.out_instr), 64'h13);
        chk("t1_hold_ireq", 64'(bus.ireq_valid), 64'd0);
        step();
        chk("t1_next_addr", bus.ireq_addr, 64'h8000_0004);
        chk("t1_next_ov", 64'(bus.out_valid), 64'd0);

        // 2: addr_ok, data_ok three cycles later
        bus.out_ready = 1'b0;
        bus.iresp_addr_ok = 1'b1;
        step();
        bus.iresp_addr_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t2_wait_ireq", 64'(bus.ireq_valid), 64'd1);
            chk("t2_wait_addr", bus.ireq_addr, 64'h8000_0004);
            chk("t2_wait_ov", 64'(bus.out_valid), 64'd0);
            step();
        end
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data = 32'hAABB_CCDD;
        chk("t2_dok_ov", 64'(bus.out_valid), 64'd0);
        step();
        bus.iresp_data_ok = 1'b0;
        chk("t2_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t2_out_pc", bus.out_pc, 64'h8000_0004);
        chk("t2_out_instr", 64'(bus.out_instr), 64'hAABB_CCDD);

        // 3: decode stalls five cycles in HOLD
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_ov", 64'(bus.out_valid), 64'd1);
            chk("t3_pc", bus.out_pc, 64'h8000_0004);
            chk("t3_instr", 64'(bus.out_instr), 64'hAABB_CCDD);
            chk("t3_ireq", 64'(bus.ireq_valid), 64'd0);
            chk("t3_addr", bus.ireq_addr, 64'h8000_0004);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t3_next_addr", bus.ireq_addr, 64'h8000_0008);

        // 4: redirect while waiting for data, stale response dropped
        bus.iresp_addr_ok = 1'b1;
        step();
        bus.iresp_addr_ok = 1'b0;
        PCSel = 1'b1;
        pc_target = 64'h8000_1000;
        step();
        PCSel = 1'b0;
        bus.out_ready = 1'b1;
        chk("t4_drop_addr", bus.ireq_addr, 64'h8000_1000);
        chk("t4_drop_ireq", 64'(bus.ireq_valid), 64'd1);
        chk("t4_drop_ov", 64'(bus.out_valid), 64'd0);
        step();
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data = 32'hDEAD_BEEF;
        chk("t4_drop_ov2", 64'(bus.out_valid), 64'd0);
        step();
        bus.iresp_data_ok = 1'b0;
        chk("t4_stale_ov", 64'(bus.out_valid), 64'd0);
        chk("t4_req_addr", bus.ireq_addr, 64'h8000_1000);
        chk("t4_req_ireq", 64'(bus.ireq_valid), 64'd1);
        step();
        chk("t4_stale_ov2", 64'(bus.out_valid), 64'd0);
        chk("t4_req_addr2", bus.ireq_addr, 64'h8000_1000);

        // 5: redirect collides with out_ready in HOLD
        bus.out_ready = 1'b0;
        bus.iresp_addr_ok = 1'b1;
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data = 32'h0010_0093;
        step();
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        chk("t5_hold_ov", 64'(bus.out_valid), 64'd1);
        chk("t5_hold_pc", bus.out_pc, 64'h8000_1000);
        PCSel = 1'b1;
        pc_target = 64'h8000_2000;
        bus.out_ready = 1'b1;
        #1;
        chk("t5_kill_ov", 64'(bus.out_valid), 64'd0);
        step();
        PCSel = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_addr", bus.ireq_addr, 64'h8000_2000);
        chk("t5_ireq", 64'(bus.ireq_valid), 64'd1);
        chk("t5_ov", 64'(bus.out_valid), 64'd0);
        bus.iresp_addr_ok = 1'b1;
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data = 32'h0000_0055;
        step();
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        chk("t5_new_pc", bus.out_pc, 64'h8000_2000);
        chk("t5_new_instr", 64'(bus.out_instr), 64'h55);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t5_adv_addr", bus.ireq_addr, 64'h8000_2004);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 64'd3);
        chk("perf_redirects", perf_redirects, 64'd2);
`endif

        // 6: reset in the middle of WAIT
        bus.iresp_addr_ok = 1'b1;
        step();
        bus.iresp_addr_ok = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rst_ireq", 64'(bus.ireq_valid), 64'd0);
        chk("t6_rst_ov", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_addr", bus.ireq_addr, 64'h8000_0000);
        chk("t6_rst_pc", bus.out_pc, 64'd0);
`ifdef FETCH_PERF_EN
        chk("perf_f_rst2", perf_fetched, 64'd0);
        chk("perf_r_rst2", perf_redirects, 64'd0);
`endif
        step();
        reset = 1'b0;
        #1;
        chk("t6_ireq", 64'(bus.ireq_valid), 64'd1);
        chk("t6_addr", bus.ireq_addr, 64'h8000_0000);
        bus.iresp_addr_ok = 1'b1;
        bus.iresp_data_ok = 1'b1;
        bus.iresp_data = 32'h0000_0077;
        step();
        bus.iresp_addr_ok = 1'b0;
        bus.iresp_data_ok = 1'b0;
        chk("t6_out_pc", bus.out_pc, 64'h8000_0000);
        chk("t6_out_instr", 64'(bus.out_instr), 64'h77);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t6_next_addr", bus.ireq_addr, 64'h8000_0004);
`ifdef FETCH_PERF_EN
        chk("perf_f_after", perf_fetched, 64'd1);
        chk("perf_r_after", perf_redirects, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
